// File: rtl/axi_lite_slave_ctrl_if.sv
// AXI4-Lite slave-side bus bundle for axi_lite_slave_ctrl.
// The slave modport is the protocol engine's view; the master modport is the bus driver's view.
interface axi_lite_slave_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_slave_ctrl.sv
// AXI4-Lite slave protocol engine: independent write and read FSMs that decode byte addresses
// to word indices and issue single-cycle strobes toward a combinational register-file backend.
module axi_lite_slave_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 16,
    localparam int unsigned IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axi_lite_slave_ctrl_if.slave    s_axi,
    output logic [IDX_W-1:0]        wr_addr,
    output logic                    wr_en,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [3:0]              wr_strb,
    output logic [IDX_W-1:0]        rd_addr,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int unsigned ADDR_LSB = 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_EXEC, RD_RESP} rd_state_t;

    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic                  r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
    logic                  r_awready, w_awready_nxt, r_wready, w_wready_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [3:0]            r_wstrb, w_wstrb_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic                  w_wr_in_range;

    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic                  r_arready, w_arready_nxt;
    logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic                  w_rd_in_range;

    // addr[MSB:2] < NUM_REGS is the same test as the full byte address < NUM_REGS*4
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return 32'(addr) < (NUM_REGS << ADDR_LSB);
    endfunction

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        w_awaddr_nxt   = r_awaddr;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_bresp_nxt    = r_bresp;
        w_bvalid_nxt   = r_bvalid;
        w_wr_in_range  = f_in_range(r_awaddr);
        wr_en          = 1'b0;
        unique case (r_wr_state)
            WR_IDLE: begin
                if (r_awready && s_axi.s_axi_awvalid) begin
                    w_awaddr_nxt  = s_axi.s_axi_awaddr;
                    w_aw_done_nxt = 1'b1;
                end
                if (r_wready && s_axi.s_axi_wvalid) begin
                    w_wdata_nxt  = s_axi.s_axi_wdata;
                    w_wstrb_nxt  = s_axi.s_axi_wstrb;
                    w_w_done_nxt = 1'b1;
                end
                if (w_aw_done_nxt && w_w_done_nxt) w_wr_state_nxt = WR_EXEC;
            end
            WR_EXEC: begin
                wr_en          = w_wr_in_range;
                w_bresp_nxt    = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                w_bvalid_nxt   = 1'b1;
                w_aw_done_nxt  = 1'b0;
                w_w_done_nxt   = 1'b0;
                w_wr_state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi.s_axi_bready) begin
                    w_bvalid_nxt   = 1'b0;
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
        // Readies are registered so they sit low through reset and drop the cycle after a handshake
        w_awready_nxt = (w_wr_state_nxt == WR_IDLE) && !w_aw_done_nxt;
        w_wready_nxt  = (w_wr_state_nxt == WR_IDLE) && !w_w_done_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_araddr_nxt   = r_araddr;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;
        w_rvalid_nxt   = r_rvalid;
        w_rd_in_range  = f_in_range(r_araddr);
        rd_en          = 1'b0;
        unique case (r_rd_state)
            RD_IDLE: begin
                if (r_arready && s_axi.s_axi_arvalid) begin
                    w_araddr_nxt   = s_axi.s_axi_araddr;
                    w_rd_state_nxt = RD_EXEC;
                end
            end
            RD_EXEC: begin
                rd_en          = 1'b1;
                w_rdata_nxt    = w_rd_in_range ? rd_data : '0;
                w_rresp_nxt    = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                w_rvalid_nxt   = 1'b1;
                w_rd_state_nxt = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi.s_axi_rready) begin
                    w_rvalid_nxt   = 1'b0;
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
        w_arready_nxt = (w_rd_state_nxt == RD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= WR_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= '0;
            r_bvalid   <= 1'b0;
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_araddr   <= '0;
            r_rdata    <= '0;
            r_rresp    <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_bresp    <= w_bresp_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_araddr   <= w_araddr_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rvalid   <= w_rvalid_nxt;
        end
    end

    assign s_axi.s_axi_awready = r_awready;
    assign s_axi.s_axi_wready  = r_wready;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;
    assign s_axi.s_axi_rvalid  = r_rvalid;

    assign wr_addr = r_awaddr[ADDR_LSB +: IDX_W];
    assign wr_data = r_wdata;
    assign wr_strb = r_wstrb;
    assign rd_addr = r_araddr[ADDR_LSB +: IDX_W];
endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// Bench for axi_lite_slave_ctrl: a combinational register-file backend plus an array-based
// reference model of the addressable words and the OKAY/SLVERR rules.
module tb_axi_lite_slave_ctrl;
    localparam int unsigned NREG = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_slave_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    logic [3:0]  wr_addr, rd_addr, wr_strb;
    logic        wr_en, rd_en;
    logic [31:0] wr_data, rd_data;

    axi_lite_slave_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NREG)) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(bus),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data)
    );

    logic [31:0] mem [NREG] = '{default: '0};
    logic [31:0] exp_mem [NREG] = '{default: '0};
    int unsigned checks = 0;
    int unsigned errors = 0;

    always @(posedge clk)
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    assign rd_data = mem[rd_addr];

    function automatic bit model_in_range(input logic [7:0] addr);
        return int'(addr) < int'(NREG * 4);
    endfunction

    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (model_in_range(addr))
            for (int b = 0; b < 4; b++)
                if (strb[b]) exp_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic void model_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        if (model_in_range(addr)) begin
            data = exp_mem[addr / 4];
            resp = 2'b00;
        end else begin
            data = '0;
            resp = 2'b10;
        end
    endfunction

    // Drives one write; valids rise aw_dly / w_dly cycles after the start, B is held for 'hold' cycles
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int unsigned aw_dly, input int unsigned w_dly, input int unsigned hold,
                             output logic [1:0] resp, output int unsigned en_cnt, output logic [3:0] en_idx,
                             output int unsigned lat, output bit proto_ok, output bit timeout);
        bit aw_done, w_done;
        int unsigned cyc;
        aw_done = 0; w_done = 0; cyc = 0; resp = '0; en_cnt = 0; en_idx = '0;
        lat = 0; proto_ok = 1; timeout = 0;
        bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
        while (!(aw_done && w_done) && !timeout) begin
            bus.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_axi_wvalid  = !w_done && (cyc >= w_dly);
            if (bus.s_axi_awvalid && bus.s_axi_awready) aw_done = 1;
            if (bus.s_axi_wvalid && bus.s_axi_wready) w_done = 1;
            if (wr_en) en_cnt++;
            @(negedge clk);
            if (++cyc > 40) timeout = 1;
        end
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        lat = 1;
        while (!bus.s_axi_bvalid && !timeout) begin
            if (wr_en) begin en_cnt++; en_idx = wr_addr; end
            @(negedge clk);
            if (++lat > 20) timeout = 1;
        end
        resp = bus.s_axi_bresp;
        if (!timeout) begin
            for (int unsigned i = 0; i < hold; i++) begin
                if (!bus.s_axi_bvalid || bus.s_axi_bresp !== resp || bus.s_axi_awready || bus.s_axi_wready || wr_en)
                    proto_ok = 0;
                @(negedge clk);
            end
            if (!bus.s_axi_bvalid) proto_ok = 0;
            bus.s_axi_bready = 1'b1;
            @(negedge clk);
            bus.s_axi_bready = 1'b0;
            if (bus.s_axi_bvalid || !bus.s_axi_awready) proto_ok = 0;
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input int unsigned hold,
                            output logic [31:0] data, output logic [1:0] resp, output int unsigned en_cnt,
                            output logic [3:0] en_idx, output int unsigned lat, output bit proto_ok,
                            output bit timeout);
        bit done;
        int unsigned cyc;
        done = 0; cyc = 0; data = '0; resp = '0; en_cnt = 0; en_idx = '0;
        lat = 0; proto_ok = 1; timeout = 0;
        bus.s_axi_araddr = addr;
        while (!done && !timeout) begin
            bus.s_axi_arvalid = 1'b1;
            if (bus.s_axi_arready) done = 1;
            @(negedge clk);
            if (++cyc > 40) timeout = 1;
        end
        bus.s_axi_arvalid = 1'b0;
        lat = 1;
        while (!bus.s_axi_rvalid && !timeout) begin
            if (rd_en) begin en_cnt++; en_idx = rd_addr; end
            @(negedge clk);
            if (++lat > 20) timeout = 1;
        end
        data = bus.s_axi_rdata; resp = bus.s_axi_rresp;
        if (!timeout) begin
            for (int unsigned i = 0; i < hold; i++) begin
                if (!bus.s_axi_rvalid || bus.s_axi_rdata !== data || bus.s_axi_rresp !== resp || bus.s_axi_arready || rd_en)
                    proto_ok = 0;
                @(negedge clk);
            end
            if (!bus.s_axi_rvalid) proto_ok = 0;
            bus.s_axi_rready = 1'b1;
            @(negedge clk);
            bus.s_axi_rready = 1'b0;
            if (bus.s_axi_rvalid || !bus.s_axi_arready) proto_ok = 0;
        end
    endtask

    task automatic test_reset();
        logic [2:0] rdy;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready} !== 3'b000) begin errors++;
            $display("FAIL reset_readies: got %b expected 000", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}); end
        checks++; if ({bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_bresp, bus.s_axi_rresp} !== 6'b0) begin errors++;
            $display("FAIL reset_resp: got %b expected 0", {bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_bresp, bus.s_axi_rresp}); end
        checks++; if ({wr_en, rd_en, wr_addr, rd_addr, wr_strb, wr_data, bus.s_axi_rdata} !== 78'b0) begin errors++;
            $display("FAIL reset_backend: got %h expected 0", {wr_en, rd_en, wr_addr, rd_addr, wr_strb, wr_data, bus.s_axi_rdata}); end
        rst_n = 1'b1;
        #1 rdy = {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready};
        checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL ready_before_clk: got %b expected 000", rdy); end
        @(negedge clk);
        rdy = {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready};
        checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL ready_after_clk: got %b expected 111", rdy); end
    endtask

    // Full write then read-back of one address, checking strobes, latency, responses and data
    task automatic write_read(input string tag, input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int unsigned aw_dly, input int unsigned w_dly);
        logic [1:0] resp, eresp;
        logic [31:0] rdat, edat;
        logic [3:0] idx;
        int unsigned en, lat;
        bit ok, to;
        axi_write(addr, data, strb, aw_dly, w_dly, 0, resp, en, idx, lat, ok, to);
        model_write(addr, data, strb);
        eresp = model_in_range(addr) ? 2'b00 : 2'b10;
        checks++; if (to || !ok) begin errors++; $display("FAIL %s_wr_proto: timeout=%0d proto_ok=%0d expected 0/1", tag, to, ok); end
        checks++; if (resp !== eresp) begin errors++; $display("FAIL %s_bresp: got %b expected %b", tag, resp, eresp); end
        checks++; if (en !== (model_in_range(addr) ? 1 : 0)) begin errors++;
            $display("FAIL %s_wr_en_count: got %0d expected %0d", tag, en, model_in_range(addr) ? 1 : 0); end
        if (model_in_range(addr)) begin
            checks++; if (idx !== 4'(addr >> 2) || lat !== 2) begin errors++;
                $display("FAIL %s_wr_idx_lat: got idx %0d lat %0d expected idx %0d lat 2", tag, idx, lat, addr >> 2); end
        end
        axi_read(addr, 0, rdat, resp, en, idx, lat, ok, to);
        model_read(addr, edat, eresp);
        checks++; if (to || !ok || en !== 1 || lat !== 2) begin errors++;
            $display("FAIL %s_rd_proto: timeout=%0d ok=%0d rd_en=%0d lat=%0d expected 0/1/1/2", tag, to, ok, en, lat); end
        checks++; if (rdat !== edat || resp !== eresp) begin errors++;
            $display("FAIL %s_rdata: got %h/%b expected %h/%b", tag, rdat, resp, edat, eresp); end
        if (model_in_range(addr)) begin
            checks++; if (idx !== 4'(addr >> 2)) begin errors++; $display("FAIL %s_rd_idx: got %0d expected %0d", tag, idx, addr >> 2); end
        end
    endtask

    task automatic test_basic();
        write_read("basic", 8'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        write_read("lsb_ignored", 8'h0B, 32'hCAFEF00D, 4'hF, 0, 0);
    endtask

    task automatic test_channel_order();
        write_read("preload", 8'h0C, 32'hAABBCCDD, 4'hF, 0, 0);
        write_read("w_first", 8'h0C, 32'h12345678, 4'b0011, 3, 0);
        write_read("aw_first", 8'h24, 32'h0BADC0DE, 4'b1100, 0, 2);
        write_read("wstrb_zero", 8'h24, 32'hFFFFFFFF, 4'b0000, 0, 0);
    endtask

    task automatic test_range();
        write_read("last_reg", 8'h3C, 32'h5A5AA5A5, 4'hF, 0, 0);
        write_read("oor_40", 8'h40, 32'h11111111, 4'hF, 0, 0);
        write_read("oor_ff", 8'hFF, 32'h22222222, 4'hF, 1, 0);
        write_read("reg0_kept", 8'h00, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic test_backpressure();
        logic [1:0] bresp, rresp;
        logic [31:0] rdat, edat;
        logic [3:0] widx, ridx;
        int unsigned wen, ren, wlat, rlat;
        bit wok, rok, wto, rto;
        model_read(8'h08, edat, rresp);
        fork
            axi_write(8'h10, 32'h0F0F0F0F, 4'hF, 0, 0, 5, bresp, wen, widx, wlat, wok, wto);
            axi_read(8'h08, 5, rdat, rresp, ren, ridx, rlat, rok, rto);
        join
        model_write(8'h10, 32'h0F0F0F0F, 4'hF);
        checks++; if (wto || !wok || bresp !== 2'b00) begin errors++;
            $display("FAIL bp_write_hold: timeout=%0d stable=%0d bresp=%b expected 0/1/00", wto, wok, bresp); end
        checks++; if (rto || !rok || rdat !== edat) begin errors++;
            $display("FAIL bp_read_hold: timeout=%0d stable=%0d rdata=%h expected 0/1/%h", rto, rok, rdat, edat); end
    endtask

    task automatic test_same_index();
        logic [1:0] bresp, rresp;
        logic [31:0] rdat, old;
        logic [3:0] widx, ridx;
        int unsigned wen, ren, wlat, rlat;
        bit wok, rok, wto, rto;
        old = exp_mem[5];
        fork
            axi_write(8'h14, 32'h76543210, 4'hF, 0, 0, 0, bresp, wen, widx, wlat, wok, wto);
            axi_read(8'h14, 0, rdat, rresp, ren, ridx, rlat, rok, rto);
        join
        model_write(8'h14, 32'h76543210, 4'hF);
        checks++; if (wto || rto || rdat !== old || rresp !== 2'b00) begin errors++;
            $display("FAIL same_idx_prewrite: timeout=%0d/%0d rdata=%h expected %h", wto, rto, rdat, old); end
        write_read("same_idx_after", 8'h14, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.s_axi_awaddr = 8'h18; bus.s_axi_wdata = 32'h600DF00D; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        model_write(8'h18, 32'h600DF00D, 4'hF);
        checks++; if (bus.s_axi_bvalid !== 1'b1) begin errors++; $display("FAIL mid_bvalid_pre: got %b expected 1", bus.s_axi_bvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.s_axi_bvalid, bus.s_axi_awready} !== 2'b00) begin errors++;
            $display("FAIL mid_reset_async: got bvalid/awready %b expected 00", {bus.s_axi_bvalid, bus.s_axi_awready}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid} !== 3'b110) begin errors++;
            $display("FAIL mid_reset_idle: got %b expected 110", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid}); end
        write_read("post_reset", 8'h1C, 32'h13579BDF, 4'hF, 0, 0);
        write_read("pre_reset_kept", 8'h18, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] addr;
        for (int n = 0; n < 30; n++) begin
            addr = 8'($urandom_range(0, 8'h4F));
            write_read($sformatf("rnd%0d", n), addr, $urandom, 4'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0; bus.s_axi_araddr = '0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
        test_reset();
        test_basic();
        test_channel_order();
        test_range();
        test_backpressure();
        test_same_index();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
